// File: rtl/rx_fifo.sv
// Receive byte FIFO between the UART receiver buffer and the host.
// Drains the receiver with a registered acknowledge and offers a first-word-fall-through read port.
module rx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [7:0]               rx_data,
    input  logic                     data_ready,
    input  logic                     framing_error,
    input  logic                     overrun_error,
    output logic                     data_read,
    input  logic                     rd_en,
    input  logic                     flush,
    output logic [7:0]               rd_data,
    output logic                     rd_ferr,
    output logic                     rd_oerr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    typedef enum logic {StIdle, StAck} state_e;

    state_e          state_q, state_d;
    logic            data_read_q, data_read_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [9:0]      mem_q [DEPTH];
    logic [9:0]      head;
    logic            do_write, do_pop;

    assign full   = (count_q == FullCount);
    assign empty  = (count_q == '0);
    assign do_pop = rd_en && !empty;

    // ACK absorbs the cycle in which the receiver still holds data_ready high.
    always_comb begin
        state_d     = state_q;
        data_read_d = 1'b0;
        do_write    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_ready && !full) begin
                    do_write    = 1'b1;
                    data_read_d = 1'b1;
                    state_d     = StAck;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            data_read_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_read_q <= data_read_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !flush) begin
            mem_q[wr_ptr_q] <= {overrun_error, framing_error, rx_data};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_write, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign rd_data   = empty ? 8'h00 : head[7:0];
    assign rd_ferr   = empty ? 1'b0  : head[8];
    assign rd_oerr   = empty ? 1'b0  : head[9];
    assign data_read = data_read_q;
    assign count     = count_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: directed scenarios plus randomized traffic, all checked against a
// queue-based reference model updated on every clock edge.
module tb_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          data_ready = 1'b0;
    logic          framing_error = 1'b0;
    logic          overrun_error = 1'b0;
    logic          data_read;
    logic          rd_en = 1'b0;
    logic          flush = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_ferr;
    logic          rd_oerr;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .data_read     (data_read),
        .rd_en         (rd_en),
        .flush         (flush),
        .rd_data       (rd_data),
        .rd_ferr       (rd_ferr),
        .rd_oerr       (rd_oerr),
        .empty         (empty),
        .full          (full),
        .count         (count)
    );

    always #5 clk = ~clk;

    // Reference: a queue of {oerr, ferr, byte}; m_dr means an acknowledge was issued on the
    // last edge, during which no new byte may be taken.
    logic [9:0] mq[$];
    logic       m_dr = 1'b0;
    logic       dr_prev = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mq.delete();
            m_dr <= 1'b0;
        end else begin
            automatic int  sz   = mq.size();
            automatic bit  take = !m_dr && data_ready && (sz < DEPTH);
            automatic bit  pop  = rd_en && (sz != 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (pop)  void'(mq.pop_front());
                if (take) mq.push_back({overrun_error, framing_error, rx_data});
            end
            m_dr <= take;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [9:0] h;
        h = (mq.size() != 0) ? mq[0] : 10'h000;
        check("count", 32'(count), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("rd_data", 32'(rd_data), 32'(h[7:0]));
        check("rd_ferr", 32'(rd_ferr), 32'(h[8]));
        check("rd_oerr", 32'(rd_oerr), 32'(h[9]));
        check("data_read", 32'(data_read), 32'(m_dr));
        check("dr_back_to_back", 32'(dr_prev & data_read), 32'd0);
        dr_prev = data_read;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
    endtask

    // Receiver behaviour: hold data_ready until acknowledged, drop it one cycle later.
    task automatic send(input logic [7:0] b, input logic fe, input logic oe, input int budget);
        bit got;
        got = 1'b0;
        rx_data       = b;
        framing_error = fe;
        overrun_error = oe;
        data_ready    = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            got = data_read;
        end
        check("ack_seen", 32'(got), 32'd1);
        cycle();
        data_ready    = 1'b0;
        framing_error = 1'b0;
        overrun_error = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    initial begin
        bit got;
        bit drop_pending;

        repeat (2) cycle();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_data_read", 32'(data_read), 32'd0);
        n_rst = 1'b1;

        // Single byte with one-cycle acknowledge latency.
        send(8'hA5, 1'b0, 1'b0, 1);
        check("t1_count", 32'(count), 32'd1);
        check("t1_data", 32'(rd_data), 32'hA5);
        check("t1_ferr", 32'(rd_ferr), 32'd0);
        pop();
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_data_empty", 32'(rd_data), 32'd0);

        // Status capture.
        send(8'h3C, 1'b1, 1'b0, 1);
        send(8'hC3, 1'b0, 1'b1, 1);
        check("t2_head0", 32'({rd_oerr, rd_ferr, rd_data}), 32'h13C);
        pop();
        check("t2_head1", 32'({rd_oerr, rd_ferr, rd_data}), 32'h2C3);
        pop();

        // Full and backpressure, then wrap.
        for (int b = 1; b <= 8; b++) send(8'(b), 1'b0, 1'b0, 1);
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd8);
        rx_data    = 8'h09;
        data_ready = 1'b1;
        repeat (3) begin
            cycle();
            check("t3_no_ack_full", 32'(data_read), 32'd0);
        end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("t3_head_after_pop", 32'(rd_data), 32'h02);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            cycle();
            got = data_read;
        end
        check("t3_ack_after_pop", 32'(got), 32'd1);
        cycle();
        data_ready = 1'b0;
        check("t3_count_refill", 32'(count), 32'd8);
        for (int b = 2; b <= 9; b++) begin
            check("t3_wrap_order", 32'(rd_data), 32'(b));
            pop();
        end

        // Simultaneous fill and pop at count 3.
        for (int b = 16; b < 19; b++) send(8'(b), 1'b0, 1'b0, 1);
        rx_data    = 8'h13;
        data_ready = 1'b1;
        rd_en      = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("t4_count", 32'(count), 32'd3);
        check("t4_ack", 32'(data_read), 32'd1);
        cycle();
        data_ready = 1'b0;
        for (int b = 17; b <= 19; b++) begin
            check("t4_order", 32'(rd_data), 32'(b));
            pop();
        end

        // Pop while empty, then flush with an acknowledge in progress.
        pop();
        check("t5_underflow_count", 32'(count), 32'd0);
        check("t5_underflow_empty", 32'(empty), 32'd1);
        for (int b = 32; b < 37; b++) send(8'(b), 1'b0, 1'b0, 1);
        check("t5_count5", 32'(count), 32'd5);
        rx_data    = 8'h25;
        data_ready = 1'b1;
        flush      = 1'b1;
        cycle();
        flush = 1'b0;
        check("t5_flush_ack", 32'(data_read), 32'd1);
        check("t5_flush_count", 32'(count), 32'd0);
        check("t5_flush_empty", 32'(empty), 32'd1);
        cycle();
        data_ready = 1'b0;
        check("t5_no_write_in_ack", 32'(count), 32'd0);

        // Reset during ACK.
        for (int b = 48; b < 51; b++) send(8'(b), 1'b0, 1'b0, 1);
        rx_data    = 8'h33;
        data_ready = 1'b1;
        cycle();
        check("t6_in_ack", 32'(data_read), 32'd1);
        check("t6_count4", 32'(count), 32'd4);
        #2;
        n_rst      = 1'b0;
        data_ready = 1'b0;
        #1;
        check("t6_dr_async", 32'(data_read), 32'd0);
        check("t6_count_async", 32'(count), 32'd0);
        check("t6_empty_async", 32'(empty), 32'd1);
        repeat (2) cycle();
        check("t6_count_held", 32'(count), 32'd0);
        n_rst = 1'b1;

        // Randomized traffic in three read-pressure phases.
        drop_pending = 1'b0;
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 800; i++) begin
                if (drop_pending) begin
                    data_ready   = 1'b0;
                    drop_pending = 1'b0;
                end else if (data_read) begin
                    drop_pending = 1'b1;
                end else if (!data_ready && $urandom_range(0, 2) == 0) begin
                    rx_data       = 8'($urandom);
                    framing_error = 1'($urandom);
                    overrun_error = 1'($urandom);
                    data_ready    = 1'b1;
                end
                case (ph)
                    0:       rd_en = ($urandom_range(0, 3) == 0);
                    1:       rd_en = ($urandom_range(0, 3) != 0);
                    default: rd_en = 1'($urandom);
                endcase
                flush = ($urandom_range(0, 63) == 0);
                cycle();
            end
        end
        rd_en      = 1'b0;
        flush      = 1'b0;
        data_ready = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive-side byte FIFO that sits directly downstream of the UART receive block. It drains each completed byte from the receiver's one-entry data buffer by pulsing `data_read`, and stores the byte with its framing/overrun status. It presents the entries to the host through a first-word-fall-through read port. When the FIFO is full it stops acknowledging, so backpressure reaches the receiver, whose overrun detection then applies.

## Interface
- `DEPTH`, default 8: number of entries; power of two, minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte from the receiver buffer.
- `data_ready`  in  1  receiver buffer holds an unread byte; level, held until acknowledged.
- `framing_error`  in  1  stop-bit status of the held byte.
- `overrun_error`  in  1  receiver overrun status.
- `data_read`  out  1  registered one-cycle acknowledge to the receiver.
- `rd_en`  in  1  host pop request.
- `flush`  in  1  synchronous clear of all entries.
- `rd_data`  out  8  head entry byte; 8'h00 when empty.
- `rd_ferr`  out  1  framing flag stored with the head entry; 0 when empty.
- `rd_oerr`  out  1  overrun flag stored with the head entry; 0 when empty.
- `empty`  out  1  no entries.
- `full`  out  1  count == `DEPTH`.
- `count`  out  $clog2(DEPTH)+1  number of entries held.

## Operation
- Storage: `DEPTH` entries of 10 bits each: {overrun, framing, byte[7:0]}.
- Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally. `count` is a separate register.
- Fill FSM has two states: IDLE and ACK.
  - IDLE → ACK when `data_ready`=1 and `full`=0. On that edge the FSM writes {`overrun_error`, `framing_error`, `rx_data`} at the write pointer, advances the write pointer, and registers `data_read`=1.
  - IDLE holds when `data_ready`=0 or `full`=1. No acknowledge is issued.
  - ACK → IDLE unconditionally; `data_read` returns to 0. This cycle covers the receiver's one-cycle delay in dropping `data_ready`, so a single byte never causes a double write.
- Pop: `rd_en`=1 with `empty`=0 advances the read pointer on the edge. `rd_en` while empty is ignored, with no underflow and no flag.
- `rd_data`, `rd_ferr` and `rd_oerr` are combinational from the entry at the read pointer, gated to 0 when empty.
- Simultaneous write and pop: both pointers advance and `count` is unchanged.
- `full` is evaluated on the current `count`. A pop in the same cycle does not enable a write in that cycle; the write happens on the next IDLE evaluation.
- `flush`=1: on the edge, both pointers and `count` are set to 0. Any write or pop in that cycle is discarded.
  - The FSM is not reset by `flush`. If a fill starts in the flush cycle, `data_read` still pulses and the FSM still moves to ACK, but the byte is lost.
- `count` stays in the range 0..`DEPTH` at all times.

## Timing
- Reset (`n_rst`=0, asynchronous):
  - FSM = IDLE, pointers = 0, `count` = 0.
  - Outputs: `data_read`=0, `empty`=1, `full`=0, `rd_data`=0, `rd_ferr`=0, `rd_oerr`=0.
  - Storage contents are don't-care.
- Reset mid-ACK: `data_read` drops immediately. The receiver byte that was already written is lost along with the FIFO contents.
- Fill latency: `data_ready` is seen high in cycle N. In cycle N+1 the entry is visible (`empty`=0, `rd_data` valid) and `data_read`=1. In cycle N+2 the FSM is back in IDLE.
- Maximum fill rate is one byte per 2 cycles. This is far above any UART bit rate, so the receiver never waits unless the FIFO is full.
- Pop latency: with `rd_en` high in cycle N, the next head entry appears in cycle N+1.
- `data_read` is never high for two consecutive cycles.

## Test plan
- Reset, then one byte: `rx_data`=8'hA5 with `data_ready` held until acknowledged, errors 0 → exactly one `data_read` pulse, one cycle after `data_ready` is seen; next cycle `count`=1, `rd_data`=8'hA5, `rd_ferr`=0; after `rd_en` → `empty`=1, `rd_data`=0.
- Status capture: byte 8'h3C with `framing_error`=1, then byte 8'hC3 with `overrun_error`=1 → the head entries read back as {ferr=1, oerr=0, 8'h3C} then {ferr=0, oerr=1, 8'hC3}.
- Full/backpressure (DEPTH=8): write bytes 0x01–0x08 → `full`=1, `count`=8. Present 0x09 → no `data_read` while full. One `rd_en` pops 0x01; within 2 cycles 0x09 is acknowledged and written and `count` returns to 8. The read-out order is then 0x02–0x09, which exercises pointer wrap.
- Simultaneous fill and pop at `count`=3 → `count` stays 3 and the order is preserved.
- `rd_en` while empty → no state change, `count`=0. `flush` at `count`=5 → next cycle `empty`=1 and `count`=0, while the FSM still completes any ACK in progress.
- Assert `n_rst` during ACK with `count`=4 → `data_read` drops asynchronously; `count`=0 and `empty`=1 until reset is released.
